// File: rtl/psel_pkg.sv
// Shared types and default sizing for the psel_arb arbiter.
package psel_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } psel_state_e;

    localparam int PSEL_WIDTH    = 4;
    localparam int PSEL_MAX_HOLD = 8;

endpackage

// File: rtl/psel_pick.sv
// Combinational winner search: descending from start, wrapping past 0 to WIDTH-1,
// over requests not masked by excl. Returns a one-hot winner.
module psel_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         req,
    input  logic [WIDTH-1:0]         excl,
    input  logic [$clog2(WIDTH)-1:0] start,
    output logic [WIDTH-1:0]         win,
    output logic                     vld
);
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] cand;
    logic [IW-1:0]    idx;
    logic             found;

    assign cand = req & ~excl;
    assign vld  = |cand;

    // WIDTH is a power of two, so index arithmetic wraps naturally.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = start - IW'(i);
            if (!found && cand[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psel_arb.sv
// Request arbiter with hold limit and forced re-arbitration. Fixed-priority
// (highest index) by default; define PSEL_ARB_RR_EN for round-robin selection.
module psel_arb
    import psel_pkg::*;
#(
    parameter int WIDTH    = PSEL_WIDTH,
    parameter int MAX_HOLD = PSEL_MAX_HOLD
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         req,
    input  logic                     en,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] gnt_idx,
    output logic                     gnt_valid,
    output logic                     req_up
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(MAX_HOLD + 1);

    psel_state_e      state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] gnt_q;
    logic [IW-1:0]    idx_q;

    logic [WIDTH-1:0] excl;
    logic [WIDTH-1:0] win;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    start;
    logic             owner_req;
    logic             expired;
    logic             keep;
    logic             load;

    assign req_up    = en & (|req);
    assign owner_req = |(req & gnt_q);
    assign expired   = (cnt_q == CW'(MAX_HOLD));
    // Only an expired owner is barred; a dropped owner has no request anyway.
    assign excl      = expired ? gnt_q : '0;

`ifdef PSEL_ARB_RR_EN
    logic [IW-1:0] ptr_q;

    assign start = ptr_q - IW'(1);

    always_ff @(posedge clock) begin
        if (!reset_n)
            ptr_q <= '0;
        else if (load)
            ptr_q <= win_idx;
    end
`else
    assign start = IW'(WIDTH - 1);
`endif

    psel_pick #(.WIDTH(WIDTH)) u_pick (
        .req   (req),
        .excl  (excl),
        .start (start),
        .win   (win),
        .vld   (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (win[i]) win_idx = IW'(i);
    end

    // Owner stays while requesting, unless it has expired and someone else waits.
    assign keep = (state_q == GRANT) && owner_req && (!expired || !win_vld);
    assign load = en && win_vld && !keep;

    always_ff @(posedge clock) begin
        if (!reset_n || !en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else if (load) begin
            state_q <= GRANT;
            cnt_q   <= CW'(1);
            gnt_q   <= win;
            idx_q   <= win_idx;
        end else if (keep) begin
            if (!expired) cnt_q <= cnt_q + CW'(1);
        end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_psel_arb.sv
// Self-checking bench for psel_arb: directed scenarios plus random traffic
// against an owner/hold-count reference model.
module tb_psel_arb;
    localparam int W  = 4;
    localparam int MH = 4;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] req     = '0;
    logic         en      = 1'b0;
    logic [W-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;
    logic         req_up;

    psel_arb #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .en        (en),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .req_up    (req_up)
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;

    // Reference state: current owner (-1 = none), cycles held, last granted index.
    int m_own  = -1;
    int m_hold = 0;
    int m_ptr  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [W-1:0] c);
`ifdef PSEL_ARB_RR_EN
        for (int k = 1; k <= W; k++) begin
            int i;
            i = (m_ptr - k + W) % W;
            if (c[i]) return i;
        end
`else
        for (int i = W - 1; i >= 0; i--)
            if (c[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_step(input logic [W-1:0] r, input logic e, input logic rs);
        logic [W-1:0] others;
        logic         own_req;
        int           p;
        others  = r;
        own_req = 1'b0;
        if (!rs) begin
            m_own = -1; m_hold = 0; m_ptr = 0;
        end else if (!e) begin
            m_own = -1; m_hold = 0;
        end else begin
            if (m_own >= 0) begin
                own_req        = r[m_own];
                others[m_own]  = 1'b0;
            end
            if (own_req && m_hold < MH) begin
                m_hold++;
            end else if (own_req && others == '0) begin
                m_hold = MH;
            end else begin
                p = pick(others);
                if (p >= 0) begin
                    m_own = p; m_hold = 1; m_ptr = p;
                end else begin
                    m_own = -1; m_hold = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [W-1:0] r, input logic e, input logic rs);
        logic [31:0] exp_gnt;
        @(negedge clock);
        req = r; en = e; reset_n = rs;
        #1;
        chk("req_up", 32'(req_up), 32'(e && (|r)));
        @(posedge clock);
        model_step(r, e, rs);
        #1;
        exp_gnt = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
        chk("gnt", 32'(gnt), exp_gnt);
        chk("gnt_idx", 32'(gnt_idx), (m_own >= 0) ? 32'(m_own) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_own >= 0));
    endtask

    initial begin
        logic [W-1:0] r;
        logic         e;
        logic         rs;

        // Reset overrides full request with enable.
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        chk("rst_gnt", 32'(gnt), 32'd0);

        // Highest requester first, then handoff with no idle cycle.
        step(4'b0101, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        chk("no_bubble", 32'(gnt), 32'd1);
        step(4'b0000, 1'b1, 1'b1);

        // Hold limit alternation between two persistent requesters.
        for (int i = 0; i < 14; i++) step(4'b1001, 1'b1, 1'b1);

        // Lone requester saturates and keeps its grant.
        step(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(4'b0010, 1'b1, 1'b1);

        // Enable drop mid-grant, then restore.
        step(4'b0010, 1'b0, 1'b1);
        step(4'b0100, 1'b1, 1'b1);
        chk("en_restore", 32'(gnt), 32'd4);

        // All requesting: forced release rotates through requesters.
        step(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 22; i++) step(4'b1111, 1'b1, 1'b1);

        // Reset mid-grant.
        step(4'b1111, 1'b1, 1'b0);
        chk("rst_mid", 32'(gnt_valid), 32'd0);

        // Random traffic; requests tend to persist so hold limits are reached.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = W'($urandom_range(0, 15));
            e  = ($urandom_range(0, 11) != 0);
            rs = ($urandom_range(0, 59) != 0);
            step(r, e, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
